// File: rtl/fpu_types_pkg.sv
// Shared half-precision FPU types: field widths and the sign-injection opcode.
package fpu_types_pkg;

  localparam int unsigned HALF_FLOAT_W    = 16;
  localparam int unsigned HALF_EXPONENT_W = 5;
  localparam int unsigned HALF_FRACTION_W = 10;

  typedef enum logic [1:0] {
    Sgnj  = 2'd0,
    Sgnjn = 2'd1,
    Sgnjx = 2'd2
  } fpu_sgnj_type_t;

endpackage

// File: rtl/float_signinj_16bit.sv
// Half-precision sign injection: magnitude from float1, sign derived per opcode.
module float_signinj_16bit
  import fpu_types_pkg::*;
(
  input  logic [HALF_FLOAT_W-1:0] float1,
  input  logic [HALF_FLOAT_W-1:0] float2,
  input  fpu_sgnj_type_t          sgnj_type,
  output logic [HALF_FLOAT_W-1:0] result
);

  localparam int unsigned MagW = HALF_EXPONENT_W + HALF_FRACTION_W;

  logic sign1, sign2, sign;

  assign sign1 = float1[HALF_FLOAT_W-1];
  assign sign2 = float2[HALF_FLOAT_W-1];

  always_comb begin
    sign = sign1;
    unique case (sgnj_type)
      Sgnj:    sign = sign2;
      Sgnjn:   sign = ~sign2;
      Sgnjx:   sign = sign1 ^ sign2;
      default: sign = sign1;
    endcase
  end

  // Exponent and fraction pass through untouched, so NaN payloads survive.
  assign result = {sign, float1[MagW-1:0]};

endmodule

// File: rtl/float_sgnj_arbiter.sv
// Round-robin arbiter sharing one sign-injection unit among NUM_REQ requesters,
// with a single registered output stage and a delivered-result counter.
module float_sgnj_arbiter
  import fpu_types_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ-1:0][HALF_FLOAT_W-1:0]  req_float1,
  input  logic [NUM_REQ-1:0][HALF_FLOAT_W-1:0]  req_float2,
  input  fpu_sgnj_type_t [NUM_REQ-1:0]          req_sgnj_type,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [HALF_FLOAT_W-1:0]               out_result,
  output logic [ID_W-1:0]                       out_id,
  output logic [15:0]                           busy_cnt
);

  logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic                    out_valid_q, out_valid_d;
  logic [HALF_FLOAT_W-1:0] out_result_q, out_result_d;
  logic [ID_W-1:0]         out_id_q, out_id_d;
  logic [15:0]             busy_cnt_q, busy_cnt_d;

  logic                    grant_valid;
  logic [ID_W-1:0]         grant_id;
  logic [ID_W-1:0]         scan_id;
  logic                    accept;
  logic [HALF_FLOAT_W-1:0] sgnj_result;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    scan_id     = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      scan_id = ID_W'((int'(rr_ptr_q) + k) % int'(NUM_REQ));
      if (!grant_valid && req_valid[scan_id]) begin
        grant_valid = 1'b1;
        grant_id    = scan_id;
      end
    end
  end

  assign accept    = grant_valid && (!out_valid_q || out_ready) && !RST;
  assign req_ready = accept ? (NUM_REQ'(1) << grant_id) : '0;

  float_signinj_16bit u_signinj (
    .float1    (req_float1[grant_id]),
    .float2    (req_float2[grant_id]),
    .sgnj_type (req_sgnj_type[grant_id]),
    .result    (sgnj_result)
  );

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_id_d     = out_id_q;
    busy_cnt_d   = busy_cnt_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_result_d = sgnj_result;
      out_id_d     = grant_id;
      rr_ptr_d     = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (out_valid_q && out_ready) begin
      busy_cnt_d = busy_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_id_q     <= '0;
      busy_cnt_q   <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_id_q     <= out_id_d;
      busy_cnt_q   <= busy_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_id     = out_id_q;
  assign busy_cnt   = busy_cnt_q;

endmodule
